// File: rtl/imem_load_ctrl_pkg.sv
// imem_load_ctrl_pkg: shared states, error codes and default parameters for the IMEM load controller
package imem_load_ctrl_pkg;
  localparam int DEPTH_DEF = 64;
  localparam int RST_HOLD_DEF = 2;
  localparam int RUN_LIMIT_DEF = 1024;
  localparam int RUN_CW = 16;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_EMPTY = 2'd3;
endpackage

// File: rtl/imem_load_ctrl_ctrl_counter.sv
// ctrl_counter: saturating up-counter with clear and enable (clear+enable yields 1)
module ctrl_counter #(
  parameter int W = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] base;
  assign base = clr ? '0 : cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || en) cnt <= (en && base != W'(MAX)) ? base + 1'b1 : base;
endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: loads a program into IMEM, then holds/releases the CPU reset and watches for program end or timeout
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH),
  parameter int RST_HOLD = RST_HOLD_DEF,
  parameter int RUN_LIMIT = RUN_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          LoadInstructions,
  input  logic [31:0]   Instruction,
  input  logic          start,
  input  logic [31:0]   cpu_pc,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  output logic [AW:0]   instr_count
);
  localparam int CW = AW + 1;
  state_t state;
  logic [3:0] hold_cnt;
  logic [RUN_CW-1:0] run_cnt;
  logic load_go, smp, full, end_prog, unused_pc;
  assign load_go = LoadInstructions && (state == S_IDLE || state == S_DONE);
  assign smp = LoadInstructions && state == S_LOAD;
  assign full = instr_count == CW'(DEPTH);
  assign end_prog = cpu_pc[31:AW+2] != '0 || {1'b0, cpu_pc[AW+1:2]} >= instr_count;
  assign unused_pc = ^cpu_pc[1:0];
  assign cpu_reset = state != S_RUN;
  assign busy = state == S_LOAD || state == S_HOLD || state == S_RUN;
  assign done = state == S_DONE;
  ctrl_counter #(.W(CW), .MAX(DEPTH)) u_count (
    .clk(clk),
    .rst(Reset),
    .clr(load_go),
    .en(load_go || (smp && !full)),
    .cnt(instr_count)
  );
  ctrl_counter #(.W(RUN_CW), .MAX(RUN_LIMIT)) u_run (
    .clk(clk),
    .rst(Reset),
    .clr(state != S_RUN),
    .en(state == S_RUN),
    .cnt(run_cnt)
  );
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      hold_cnt <= '0;
      err <= ERR_NONE;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE:
          if (LoadInstructions) begin
            state <= S_LOAD;
            err <= ERR_NONE;
            imem_we <= 1'b1;
            imem_addr <= '0;
            imem_wdata <= Instruction;
          end else if (start && instr_count == '0) err <= ERR_EMPTY;
          else if (start) begin
            state <= S_HOLD;
            err <= ERR_NONE;
            hold_cnt <= '0;
          end
        S_LOAD:
          if (!LoadInstructions) state <= S_IDLE;
          else if (full) err <= ERR_OVF;
          else begin
            imem_we <= 1'b1;
            imem_addr <= instr_count[AW-1:0];
            imem_wdata <= Instruction;
          end
        S_HOLD:
          if (hold_cnt == 4'(RST_HOLD - 1)) state <= S_RUN;
          else hold_cnt <= hold_cnt + 1'b1;
        S_RUN:
          if (end_prog) state <= S_DONE;
          else if (run_cnt == RUN_CW'(RUN_LIMIT - 1)) begin
            state <= S_DONE;
            err <= ERR_TIMEOUT;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: randomized load/run scenarios checked against a transaction-level model
module tb_imem_load_ctrl;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int RST_HOLD = 2;
  localparam int RUN_LIMIT = 8;
  logic clk = 1'b0;
  logic Reset, LoadInstructions, start;
  logic [31:0] Instruction, cpu_pc;
  logic imem_we, cpu_reset, busy, done;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0] err;
  logic [AW:0] instr_count;
  int checks = 0;
  int failures = 0;
  logic [AW-1:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] words[$];
  imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW), .RST_HOLD(RST_HOLD), .RUN_LIMIT(RUN_LIMIT)) dut (
    .clk(clk),
    .Reset(Reset),
    .LoadInstructions(LoadInstructions),
    .Instruction(Instruction),
    .start(start),
    .cpu_pc(cpu_pc),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .err(err),
    .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rand_end(input int c);
    if ($urandom_range(0, 1) == 1) return $urandom | 32'h8000_0000;
    return $urandom_range(c * 4, 4 * DEPTH + 7);
  endfunction
  task automatic load(input int n);
    int exp;
    wa.delete();
    wd.delete();
    words.delete();
    for (int i = 0; i < n; i++) begin
      Instruction = $urandom;
      words.push_back(Instruction);
      LoadInstructions = 1'b1;
      start = 1'($urandom_range(0, 1));
      tick();
    end
    LoadInstructions = 1'b0;
    start = 1'b0;
    tick();
    exp = n > DEPTH ? DEPTH : n;
    check("wr_cnt", wa.size(), exp);
    for (int i = 0; i < wa.size() && i < exp; i++) begin
      check("wr_addr", 32'(wa[i]), i);
      check("wr_data", wd[i], words[i]);
    end
    check("count", 32'(instr_count), exp);
    check("load_err", 32'(err), n > DEPTH ? 1 : 0);
    check("load_idle", {busy, done}, 0);
    check("addr_hold", 32'(imem_addr), exp - 1);
    check("wdata_hold", imem_wdata, words[exp-1]);
  endtask
  task automatic run(input int k, input logic [31:0] end_pc, input bit zero_pc);
    int cnt, exit_r, bad, wr0;
    cnt = int'(instr_count);
    exit_r = -1;
    bad = 0;
    wr0 = wa.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_err_clr", 32'(err), 0);
    for (int h = 0; h < RST_HOLD; h++) begin
      if (!cpu_reset || !busy || done) bad++;
      tick();
    end
    check("hold_rst", bad, 0);
    check("run_entry_rst", 32'(cpu_reset), 0);
    for (int r = 0; r < RUN_LIMIT + 4; r++) begin
      cpu_pc = r == k ? end_pc : zero_pc ? 32'd0 : $urandom_range(0, cnt * 4 - 1);
      if (cpu_reset || !busy) bad++;
      tick();
      if (done) begin
        exit_r = r;
        break;
      end
    end
    cpu_pc = 32'd0;
    check("run_exit", exit_r, k < RUN_LIMIT ? k : RUN_LIMIT - 1);
    check("run_err", 32'(err), k < RUN_LIMIT ? 0 : 2);
    check("run_rst_low", bad, 0);
    check("done_rst", {cpu_reset, busy}, 2'b10);
    check("run_count", 32'(instr_count), cnt);
    check("run_nowr", wa.size(), wr0);
  endtask
  initial begin
    Reset = 1'b1;
    LoadInstructions = 1'b0;
    start = 1'b0;
    Instruction = 32'd0;
    cpu_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(imem_we), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu", 32'(cpu_reset), 1);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_err", 32'(err), 0);
    check("rst_count", 32'(instr_count), 0);
    Reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_err", 32'(err), 3);
    check("empty_idle", {busy, done}, 0);
    tick();
    check("empty_stay", {busy, 30'd0, err}, 3);
    load(11);
    run(3, 32'd44, 1'b0);
    run($urandom_range(0, RUN_LIMIT - 1), rand_end(11), 1'b0);
    run(RUN_LIMIT + 10, 32'd0, 1'b1);
    load(20);
    check("ovf_sticky", 32'(err), 1);
    run(RUN_LIMIT - 1, rand_end(DEPTH), 1'b0);
    load(DEPTH);
    run($urandom_range(0, 3), rand_end(DEPTH), 1'b0);
    for (int it = 0; it < 8; it++) begin
      load($urandom_range(1, DEPTH + 4));
      run($urandom_range(0, RUN_LIMIT + 2), rand_end(int'(instr_count)), $urandom_range(0, 3) == 0);
    end
    load(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RST_HOLD + 2) tick();
    #2 Reset = 1'b1;
    #1;
    check("arst_run_cpu", 32'(cpu_reset), 1);
    check("arst_run_count", 32'(instr_count), 0);
    check("arst_run_state", {busy, done}, 0);
    @(posedge clk);
    #1 Reset = 1'b0;
    tick();
    check("arst_idle", {busy, done, err}, 0);
    LoadInstructions = 1'b1;
    Instruction = $urandom;
    repeat (3) tick();
    check("mid_load_we", 32'(imem_we), 1);
    #2 Reset = 1'b1;
    #1;
    check("arst_load_we", 32'(imem_we), 0);
    check("arst_load_addr", {imem_addr, instr_count}, 0);
    LoadInstructions = 1'b0;
    @(posedge clk);
    #1 Reset = 1'b0;
    tick();
    check("arst_load_idle", {busy, 30'd0, imem_we}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter: DEPTH, 64, instruction memory depth in words (power of two, 2..1024).
REQ-002 Parameter: AW, log2(DEPTH), IMEM word-address width.
REQ-003 Parameter: RST_HOLD, 2, cycles the CPU is held in reset before RUN (1..15).
REQ-004 Parameter: RUN_LIMIT, 1024, maximum RUN cycles before timeout (1..65535).
REQ-005 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port: Reset  in  1  asynchronous, active-high reset.
REQ-007 Port: LoadInstructions  in  1  level; high = load phase requested.
REQ-008 Port: Instruction  in  32  instruction word, sampled when LoadInstructions high in LOAD.
REQ-009 Port: start  in  1  single-cycle pulse; begins execution of the loaded program.
REQ-010 Port: cpu_pc  in  32  CPU byte PC; used for end-of-program detection.
REQ-011 Port: imem_we  out  1  IMEM write enable.
REQ-012 Port: imem_addr  out  AW  IMEM word address.
REQ-013 Port: imem_wdata  out  32  IMEM write data.
REQ-014 Port: cpu_reset  out  1  active-high reset to the CPU core.
REQ-015 Port: busy  out  1  high in LOAD, HOLD, RUN.
REQ-016 Port: done  out  1  high in DONE.
REQ-017 Port: err  out  2  0 none, 1 overflow, 2 timeout, 3 empty-start.
REQ-018 Port: instr_count  out  AW+1  number of words loaded.

Function
REQ-019 FSM states IDLE, LOAD, HOLD, RUN, DONE; encoding in shared package.
REQ-020 IDLE: LoadInstructions high -> LOAD on next edge; count cleared to 0 on that transition.
REQ-021 LOAD: each cycle with LoadInstructions high, imem_we=1, imem_addr=count[AW-1:0], imem_wdata=Instruction, count+1; registered outputs, write visible 1 cycle after sample.
REQ-022 LOAD: LoadInstructions low -> IDLE; count retained.
REQ-023 LOAD: sample arriving with count==DEPTH -> no write, err=1, word discarded, stay LOAD; count saturates at DEPTH.
REQ-024 start in IDLE with count==0 -> err=3, stay IDLE; start in IDLE with count>0 -> HOLD, err cleared.
REQ-025 start in any state other than IDLE ignored; start and LoadInstructions simultaneous in IDLE -> LOAD wins.
REQ-026 HOLD: cpu_reset=1 for exactly RST_HOLD cycles, then RUN.
REQ-027 RUN: cpu_reset=0; run counter increments every cycle from 0.
REQ-028 RUN: cpu_pc[AW+1:2] >= count and cpu_pc[31:AW+2]==0, or cpu_pc[31:AW+2]!=0 -> DONE next edge (program fell off end).
REQ-029 RUN: run counter reaching RUN_LIMIT -> DONE with err=2; end-of-program in same cycle takes priority (err=0).
REQ-030 DONE: cpu_reset=1 (core frozen); LoadInstructions high -> LOAD (count cleared); start -> HOLD (rerun same program).
REQ-031 cpu_reset=1 in IDLE, LOAD, HOLD, DONE; 0 only in RUN.
REQ-032 imem_we=0 outside LOAD; imem_addr/wdata hold last value when imem_we=0.
REQ-033 err sticky until next LOAD entry or accepted start.

Reset
REQ-034 Reset asserted: state=IDLE, count=0, run counter=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, busy=0, done=0, err=0; asynchronous, effective mid-write or mid-run, no partial write issued after assertion.
REQ-035 Release: first active edge after Reset deasserts evaluates IDLE transitions.

Structure
REQ-036 Shared package holds state enum, err code constants, and default parameter values.
REQ-037 One sub-module, ctrl_counter (saturating up-counter with clear/enable), instantiated for count and run counter.
REQ-038 Total RTL 120-400 lines; no combinational path from inputs to imem_* outputs.

Verification
REQ-039 Load 11 words with LoadInstructions high 11 cycles -> 11 writes addr 0..10, data match, instr_count=11, state IDLE.
REQ-040 start after load, RST_HOLD=2 -> cpu_reset high 2 cycles then low; cpu_pc driven to 44 -> done=1, err=0, cpu_reset=1 next cycle.
REQ-041 DEPTH=4, load 6 words -> 4 writes, err=1, instr_count=4.
REQ-042 start with count=0 -> err=3, no HOLD; RUN_LIMIT=8 with cpu_pc stuck at 0 -> DONE after 8 RUN cycles, err=2.
REQ-043 Reset pulsed at 3rd RUN cycle -> IDLE, cpu_reset=1, count=0 immediately (asynchronous, before next edge).
REQ-044 From DONE, start -> rerun with same count; LoadInstructions -> count restarts at 0, err cleared.
